// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the multiplexed 7-segment driver.
//   - GLYPH_0 .. GLYPH_F : active-low abcdefg patterns (bit 6 = a, bit 0 = g)
//   - SEG_BLANK          : all segments dark in active-low form
//   - hex_to_glyph()     : nibble -> active-low glyph
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0   = 7'h01;
    localparam logic [6:0] GLYPH_1   = 7'h4F;
    localparam logic [6:0] GLYPH_2   = 7'h12;
    localparam logic [6:0] GLYPH_3   = 7'h06;
    localparam logic [6:0] GLYPH_4   = 7'h4C;
    localparam logic [6:0] GLYPH_5   = 7'h24;
    localparam logic [6:0] GLYPH_6   = 7'h20;
    localparam logic [6:0] GLYPH_7   = 7'h0F;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h04;
    localparam logic [6:0] GLYPH_A   = 7'h08;
    localparam logic [6:0] GLYPH_B   = 7'h60;
    localparam logic [6:0] GLYPH_C   = 7'h31;
    localparam logic [6:0] GLYPH_D   = 7'h42;
    localparam logic [6:0] GLYPH_E   = 7'h30;
    localparam logic [6:0] GLYPH_F   = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seven_segment_mux_n_if.sv
// -----------------------------------------------------------------------------
// seven_segment_mux_n_if
// Display-side bundle of the multiplexed 7-segment driver.
//   master : data source (drives digits/dp_in/blank/lz_suppress/brightness/load)
//   slave  : the driver (drives seg_data/dp_out/AN_value/frame_tick)
// There is no handshake: load is a single-cycle capture strobe and the outputs
// are level signals refreshed every clock; frame_tick marks each frame start.
// -----------------------------------------------------------------------------
interface seven_segment_mux_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_suppress;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    load;
    logic [6:0]              seg_data;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   AN_value;
    logic                    frame_tick;

    modport master (
        output digits, dp_in, blank, lz_suppress, brightness, load,
        input  seg_data, dp_out, AN_value, frame_tick
    );

    modport slave (
        input  digits, dp_in, blank, lz_suppress, brightness, load,
        output seg_data, dp_out, AN_value, frame_tick
    );
endinterface

// File: rtl/seven_seg_lz_mask.sv
// -----------------------------------------------------------------------------
// seven_seg_lz_mask
// Combinational leading-zero mask.
//   i_digits : NUM_DIGITS hex nibbles, digit 0 in bits 3:0
//   i_enable : suppression enable
//   o_mask   : bit i set when digit i must be shown dark
// Digit i (i >= 1) is masked when every digit from i upward is zero; digit 0
// is never masked so a zero value still shows one "0".
// -----------------------------------------------------------------------------
module seven_seg_lz_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic                    i_enable,
    output logic [NUM_DIGITS-1:0]   o_mask
);
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        o_mask     = '0;
        // Walk from the most significant digit down; the run of zeros breaks
        // at the first non-zero digit and stays broken below it.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_zero_run = v_zero_run && (i_digits[4*i +: 4] == 4'h0);
            o_mask[i]  = i_enable && v_zero_run;
        end
    end
endmodule

// File: rtl/seven_segment_mux_n.sv
// -----------------------------------------------------------------------------
// seven_segment_mux_n
// Time-multiplexed driver for N common-anode 7-segment digits.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : seven_segment_mux_n_if.slave (digit data in, display pins out)
// Each digit owns a slot of 2^PRESCALE_BITS clocks. Digit data is captured
// into shadow registers on load and copied to the active registers only at
// the frame boundary, so a frame never mixes old and new values. All pin
// outputs are registered one clock behind the counter state producing them.
// -----------------------------------------------------------------------------
module seven_segment_mux_n
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_BITS  = 16,
    parameter int BRIGHT_W       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_segment_mux_n_if.slave bus
);
    localparam int                      IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [PRESCALE_BITS-1:0] CNT_MAX = {PRESCALE_BITS{1'b1}};
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]              SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
    localparam logic                    DP_ON    = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0]   AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};

    logic [PRESCALE_BITS-1:0] r_slot_cnt;
    logic [IDX_W-1:0]         r_dig_idx;
    logic [4*NUM_DIGITS-1:0]  r_shadow_digits, r_act_digits;
    logic [NUM_DIGITS-1:0]    r_shadow_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]    r_shadow_blank, r_act_blank;
    logic [NUM_DIGITS-1:0]    r_an;
    logic [6:0]               r_seg;
    logic                     r_dp;
    logic                     r_frame_tick;

    logic                     w_slot_wrap;
    logic                     w_frame_end;
    logic                     w_pwm_on;
    logic                     w_digit_on;
    logic [3:0]               w_cur_nib;
    logic [6:0]               w_glyph_raw;
    logic [6:0]               w_glyph;
    logic [NUM_DIGITS-1:0]    w_an_onehot;
    logic [NUM_DIGITS-1:0]    w_an_sel;
    logic [NUM_DIGITS-1:0]    w_lz_mask;

    seven_seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .i_digits (r_act_digits),
        .i_enable (bus.lz_suppress),
        .o_mask   (w_lz_mask)
    );

    assign w_slot_wrap = (r_slot_cnt == CNT_MAX);
    assign w_frame_end = w_slot_wrap && (r_dig_idx == IDX_LAST);
    // The top BRIGHT_W bits of the slot counter step through 2^BRIGHT_W
    // sub-slots; even full brightness leaves the last sub-slot dark as a
    // ghosting guard between digits.
    assign w_pwm_on    = r_slot_cnt[PRESCALE_BITS-1 -: BRIGHT_W] < bus.brightness;
    assign w_digit_on  = w_pwm_on && !r_act_blank[r_dig_idx];
    assign w_cur_nib   = r_act_digits[4*r_dig_idx +: 4];
    assign w_glyph_raw = hex_to_glyph(w_cur_nib);
    assign w_glyph     = (SEG_ACTIVE_LOW != 0) ? w_glyph_raw : ~w_glyph_raw;
    assign w_an_onehot = NUM_DIGITS'(1) << r_dig_idx;
    assign w_an_sel    = (AN_ACTIVE_LOW != 0) ? ~w_an_onehot : w_an_onehot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_cnt      <= '0;
            r_dig_idx       <= '0;
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
            r_shadow_blank  <= '0;
            r_act_digits    <= '0;
            r_act_dp        <= '0;
            r_act_blank     <= '0;
            r_an            <= AN_OFF;
            r_seg           <= SEG_OFF;
            r_dp            <= ~DP_ON;
            r_frame_tick    <= 1'b0;
        end else begin
            r_slot_cnt <= r_slot_cnt + PRESCALE_BITS'(1);
            if (w_slot_wrap) begin
                r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + IDX_W'(1);
            end

            if (bus.load) begin
                r_shadow_digits <= bus.digits;
                r_shadow_dp     <= bus.dp_in;
                r_shadow_blank  <= bus.blank;
            end

            // A load on the boundary cycle is forwarded straight to the
            // active set; the shadow would still hold the previous value.
            if (w_frame_end) begin
                r_act_digits <= bus.load ? bus.digits : r_shadow_digits;
                r_act_dp     <= bus.load ? bus.dp_in  : r_shadow_dp;
                r_act_blank  <= bus.load ? bus.blank  : r_shadow_blank;
            end
            r_frame_tick <= w_frame_end;

            if (w_digit_on) begin
                r_an  <= w_an_sel;
                r_seg <= w_lz_mask[r_dig_idx] ? SEG_OFF : w_glyph;
                r_dp  <= r_act_dp[r_dig_idx] ? DP_ON : ~DP_ON;
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= ~DP_ON;
            end
        end
    end

    assign bus.AN_value   = r_an;
    assign bus.seg_data   = r_seg;
    assign bus.dp_out     = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_mux_n.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux_n
// Scoreboard bench: the driver pushes the display state the reference model
// predicts for each upcoming clock edge; a monitor pops and compares after it.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux_n;
  localparam int N     = 4;
  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = 2 ** P;
  localparam int FRAME = SLOT * N;
  localparam int STEP  = SLOT / (2 ** B);
  localparam int W     = N + 7 + 1 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_segment_mux_n_if #(.NUM_DIGITS(N), .BRIGHT_W(B)) bus ();

  seven_segment_mux_n #(
    .NUM_DIGITS(N), .PRESCALE_BITS(P), .BRIGHT_W(B),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // lit segments of each hex glyph, letters a..g
  string seg_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // reference model state: elapsed clocks since reset release and the
  // shadow/displayed digit sets
  int            m_s;
  logic [4*N-1:0] m_sh_dig, m_act_dig;
  logic [N-1:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;

  function automatic logic [6:0] ref_glyph(input int v);
    logic [6:0] g;
    string s;
    g = 7'h7F;
    s = seg_lit[v];
    for (int i = 0; i < s.len(); i++) g[6 - (int'(s[i]) - 97)] = 1'b0;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // predict the outputs the next clock edge produces, then advance the model
  task automatic model_push();
    int cnt, idx, nib;
    bit on, sup, tick;
    logic [N-1:0] an_e;
    logic [6:0] seg_e;
    logic dp_e;
    if (reset == 1'b0) begin
      m_s = 0;
      m_sh_dig = '0; m_act_dig = '0;
      m_sh_dp = '0; m_act_dp = '0; m_sh_bl = '0; m_act_bl = '0;
      an_e = '1; seg_e = 7'h7F; dp_e = 1'b1; tick = 1'b0;
    end else begin
      cnt  = m_s % SLOT;
      idx  = (m_s / SLOT) % N;
      nib  = int'((m_act_dig >> (4 * idx)) & 16'hF);
      on   = ((cnt / STEP) < int'(bus.brightness)) && (m_act_bl[idx] == 1'b0);
      sup  = bus.lz_suppress && (idx > 0) && ((m_act_dig >> (4 * idx)) == 0);
      an_e  = on ? ~(N'(1) << idx) : '1;
      seg_e = (on && !sup) ? ref_glyph(nib) : 7'h7F;
      dp_e  = on ? ~m_act_dp[idx] : 1'b1;
      tick  = (m_s % FRAME) == FRAME - 1;
      if (tick) begin
        m_act_dig = bus.load ? bus.digits : m_sh_dig;
        m_act_dp  = bus.load ? bus.dp_in  : m_sh_dp;
        m_act_bl  = bus.load ? bus.blank  : m_sh_bl;
      end
      if (bus.load) begin
        m_sh_dig = bus.digits; m_sh_dp = bus.dp_in; m_sh_bl = bus.blank;
      end
      m_s++;
    end
    exp_q.push_back({an_e, seg_e, dp_e, tick});
  endtask

  task automatic step();
    model_push();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] bl);
    bus.digits = d; bus.dp_in = dp; bus.blank = bl; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic go_phase(input int ph);
    for (int k = 0; k < FRAME && (m_s % FRAME) != ph; k++) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    chk("rst_an", 32'(bus.AN_value), 32'hF);
    chk("rst_seg", 32'(bus.seg_data), 32'h7F);
    chk("rst_dp", 32'(bus.dp_out), 32'h1);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    step();
    step();
    reset = 1'b1;
  endtask

  // monitor: compare every output the DUT presents after a clock edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("an", 32'(bus.AN_value), 32'(e[W-1 -: N]));
        chk("seg", 32'(bus.seg_data), 32'(e[8:2]));
        chk("dp", 32'(bus.dp_out), 32'(e[1]));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e[0]));
      end
    end
  end

  initial begin
    bus.digits = 16'(N'($urandom)); bus.digits = 16'($urandom);
    bus.dp_in = N'($urandom); bus.blank = N'($urandom);
    bus.lz_suppress = 1'($urandom); bus.brightness = B'($urandom);
    bus.load = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("init_an", 32'(bus.AN_value), 32'hF);
    chk("init_seg", 32'(bus.seg_data), 32'h7F);
    chk("init_dp", 32'(bus.dp_out), 32'h1);
    chk("init_tick", 32'(bus.frame_tick), 32'h0);
    run(3);

    // release: nothing loaded yet, first frame_tick after one full frame
    bus.digits = '0; bus.dp_in = '0; bus.blank = '0; bus.load = 1'b0;
    bus.lz_suppress = 1'b0; bus.brightness = 2'd3;
    reset = 1'b1;
    run(FRAME + 6);

    // scan and decode
    do_load(16'h1A2F, 4'b0000, 4'b0000);
    run(2 * FRAME);

    // leading-zero suppression
    bus.lz_suppress = 1'b1;
    do_load(16'h0040, 4'b0000, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0010, 4'b0000);
    run(2 * FRAME);
    bus.lz_suppress = 1'b0;

    // no tearing: mid-frame load waits, boundary load is forwarded
    do_load(16'h1234, 4'b0000, 4'b0000);
    go_phase(0);
    go_phase(20);
    do_load(16'h5555, 4'b0000, 4'b0000);
    run(2 * FRAME);
    go_phase(FRAME - 1);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    run(FRAME);

    // brightness, blank, decimal point
    bus.brightness = 2'd0;
    run(FRAME + 2);
    bus.brightness = 2'd3;
    do_load(16'h6789, 4'b0000, 4'b0100);
    run(2 * FRAME);
    do_load(16'h6789, 4'b0001, 4'b0000);
    run(2 * FRAME);
    bus.brightness = 2'd1;
    run(FRAME);
    bus.brightness = 2'd2;
    run(FRAME);
    bus.brightness = 2'd3;

    // reset inside digit 2's lit window
    go_phase(2 * SLOT + 3);
    reset_pulse();
    run(2 * FRAME);

    // randomized operation
    for (int c = 0; c < 120 * FRAME; c++) begin
      if ($urandom_range(0, 2999) == 0) begin
        reset_pulse();
      end else if ($urandom_range(0, 19) == 0) begin
        do_load(16'($urandom), N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      end else begin
        if ($urandom_range(0, 49) == 0) bus.brightness = B'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) bus.lz_suppress = 1'($urandom);
        step();
      end
    end

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_segment_mux_n.md
Name: seven_segment_mux_n

Overview:
- Parametrised time-multiplexed driver for common-anode 7-segment displays with N digits.
- Decodes the full 0-F hex range and drives per-digit decimal points, per-digit blanking, leading-zero suppression and PWM brightness.
- Digit values are double-buffered and applied only at frame boundaries, so the display never tears.
- Sits between datapath/UART status logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits; range 2..8.
- PRESCALE_BITS, 16: width of the slot counter; each digit is displayed for 2^PRESCALE_BITS clocks. Must be >= BRIGHT_W.
- BRIGHT_W, 4: width of the brightness control.
- SEG_ACTIVE_LOW, 1: if 1, segments and dp are lit when driven 0.
- AN_ACTIVE_LOW, 1: if 1, the selected anode is driven 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- digits  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, and digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blank  in  NUM_DIGITS  force digit i dark
- lz_suppress  in  1  enable leading-zero suppression
- brightness  in  BRIGHT_W  PWM duty; 0 = off
- load  in  1  strobe that captures digits, dp_in and blank into shadow registers
- seg_data  out  7  segments; bit 6 = a … bit 0 = g
- dp_out  out  1  decimal point
- AN_value  out  NUM_DIGITS  anode enables; bit i selects digit i
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset, asynchronous on reset low:
  - slot counter = 0, digit index = 0.
  - Shadow and active registers = 0.
  - AN_value all inactive; seg_data all unlit (7'h7F when SEG_ACTIVE_LOW); dp_out unlit; frame_tick = 0.
  - Asserting reset mid-frame blanks the outputs on the same edge.
- Shadow capture: on a clock edge with load=1, the shadow registers take digits, dp_in and blank. brightness and lz_suppress are sampled live.
- Slot counter:
  - Increments every clock and wraps from 2^PRESCALE_BITS-1 to 0.
  - On wrap, the digit index increments; it wraps from NUM_DIGITS-1 to 0, including non-power-of-2 counts.
- Frame boundary: the clock on which the index wraps to 0.
  - Active registers copy the shadow registers.
  - frame_tick = 1 for exactly that cycle.
  - If load coincides with a frame boundary, the active registers take the incoming port values (load forwarded), not the stale shadow.
- Leading-zero suppression mask: computed from the active digits.
  - Digit i (i >= 1) is suppressed when lz_suppress=1 and all digits j >= i are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A suppressed digit's dp is still shown if requested.
- Decode:
  - 0-9 use standard glyphs.
  - A, b, C, d, E, F use conventional glyphs (active-low abcdefg: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000).
  - SEG_ACTIVE_LOW=0 inverts all glyphs.
- Digit on-condition: a digit is on when
  - slot_cnt[PRESCALE_BITS-1 -: BRIGHT_W] < brightness, and
  - its blank bit is 0.
  - When on: AN_value selects the digit, seg_data = glyph (or all unlit if the digit is LZ-suppressed), dp_out = dp bit.
  - When not on: AN_value all inactive, seg_data and dp_out unlit.
- Duty and ghosting:
  - Duty is brightness/2^BRIGHT_W; maximum brightness leaves a 1/2^BRIGHT_W dark guard per slot.
  - The guard and the registered anode/segment update prevent ghosting.
- Latency: all outputs are registered, one clock after the counter state that produces them. Anode and segment change on the same edge.

Decomposition:
- Package seven_seg_pkg holds:
  - 7-bit glyph constants for 0-F and SEG_BLANK.
  - Function hex_to_glyph(nibble) returning active-low abcdefg.
- One sub-module, seven_seg_lz_mask: combinational; NUM_DIGITS nibbles plus enable in, suppression mask out.
- The counter, PWM comparator and output registers live in the top module.

Test Plan:
- Sim parameters: NUM_DIGITS=4, PRESCALE_BITS=4, BRIGHT_W=2.
- Reset: hold reset=0 for 3 clocks with arbitrary inputs -> AN_value=4'b1111, seg_data=7'h7F, dp_out=1, frame_tick=0. Release -> first frame_tick after 4*16 clocks.
- Scan and decode: load digits=16'h1A2F, brightness=3 -> after the next frame_tick:
  - AN cycles 1110, 1101, 1011, 0111, each lit for 12 of 16 clocks.
  - seg_data = F, 2, A, 1 glyphs respectively.
  - All anodes inactive for the last 4 clocks of each slot.
- Leading-zero suppression: digits=16'h0040, lz_suppress=1 -> digits 3 and 2 unlit (seg 7'h7F while their anode is active), digit 1 = "4", digit 0 = "0". digits=16'h0000 -> only digit 0 shows "0".
- No tearing: pulse load with 16'h5555 mid-frame -> the current frame still shows the old value. The new value appears on the digit-0 slot following frame_tick. load on the frame_tick cycle -> the new value is used immediately.
- Brightness, blank and dp:
  - brightness=0 -> AN_value stays 4'b1111 for a full frame.
  - blank=4'b0100 -> digit 2 anode never active.
  - dp_in=4'b0001 -> dp_out=0 only during digit 0's lit window.
- Reset mid-operation: assert reset during the digit-2 lit window -> outputs unlit on that edge. After release, scanning restarts at digit 0 with active digits=0.
